branch_resolve: RTL and testbench
=================================

BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 Parameter: FLUSH_CYCLES, default 1, number of cycles flush stays high after a taken branch (legal 1..3).
REQ-002 Parameter: ADDR_W, default 64, branch target width.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 ex_valid  input  1  EX-stage instruction valid.
REQ-006 ex_set_flags  input  1  EX instruction writes flags (ADDS/SUBS).
REQ-007 alu_neg, alu_zero, alu_cout, alu_ovf  input  1 each  ALU flags; alu_zero comes from the 64-bit zero detector.
REQ-008 id_valid  input  1  ID-stage branch candidate valid.
REQ-009 id_br_type  input  2  00 NONE, 01 B, 10 CBZ, 11 B.LT.
REQ-010 id_reg_zero  input  1  zero-detect of the CBZ register operand.
REQ-011 id_target  input  ADDR_W  branch target address.
REQ-012 take_branch  output  1  registered taken pulse, one cycle.
REQ-013 pc_target  output  ADDR_W  registered target, valid while take_branch is high.
REQ-014 flush  output  1  squash younger pipeline stages.
REQ-015 stall  output  1  hold ID stage; upstream keeps id_* stable while it is high.
REQ-016 flags_q  output  4  architectural flags {N,Z,C,V}.

Function
REQ-017 FSM states RUN, STALL, FLUSH; reset state RUN.
REQ-018 flags_q <= {alu_neg,alu_zero,alu_cout,alu_ovf} at the edge where ex_valid&ex_set_flags=1; otherwise hold.
REQ-019 Decision terms: B always taken; CBZ taken iff id_reg_zero=1; B.LT taken iff N!=V of the effective flags; NONE never taken.
REQ-020 RUN, id_valid=1, taken: next edge take_branch=1, pc_target=id_target, state->FLUSH with counter=FLUSH_CYCLES; latency 1 cycle.
REQ-021 take_branch high exactly one cycle per taken branch; pc_target holds its last value otherwise.
REQ-022 FLUSH: flush=1; counter decrements each cycle; at 1 -> RUN; id_valid ignored (squashed) throughout.
REQ-023 flush=1 only in FLUSH; stall=1 only in STALL (combinational from state).
REQ-024 Not-taken branch or id_valid=0 in RUN: no outputs change, state stays RUN.
REQ-025 Flag update and FLUSH are independent; flags still update during FLUSH and STALL.
REQ-026 Simultaneous ex flag write and B/CBZ: no interaction; B/CBZ never stall.

Reset
REQ-027 reset=1 at an edge: state RUN, counter 0, flags_q=4'b0000, take_branch=0, pc_target=0, flush=0, stall=0.
REQ-028 reset overrides every concurrent event, including mid-FLUSH and mid-STALL; no pending branch survives.

Configuration
REQ-029 Macro FLAG_FWD_EN defined: B.LT uses forwarded flags from alu_* when ex_valid&ex_set_flags, else flags_q; never enters STALL.
REQ-030 FLAG_FWD_EN undefined: B.LT with ex_valid&ex_set_flags in the same cycle -> STALL one cycle, then resolves from updated flags_q in RUN-equivalent fashion; otherwise uses flags_q.

Structure
REQ-031 Shared package holds br_type_t enum (NONE/B/CBZ/BLT), fsm state enum, flag bit index constants N=3,Z=2,C=1,V=0.
REQ-032 One sub-module flag_reg (4-bit enable register with synchronous reset) is natural; decision logic and FSM stay in branch_resolve.

Verification
REQ-033 Reset then idle 5 cycles -> flags_q=0000, take_branch/flush/stall=0.
REQ-034 SUBS with alu_zero=1, alu_neg=0 -> next cycle flags_q=0100; CBZ with id_reg_zero=1, id_target=64'h40 -> take_branch=1, pc_target=64'h40, flush=1 for 1 cycle.
REQ-035 flags_q N=1,V=0, B.LT target 64'h100 -> taken; N=1,V=1 -> not taken, no flush.
REQ-036 SUBS (alu_neg=1,alu_ovf=0) same cycle as B.LT: FLAG_FWD_EN -> taken next cycle, stall=0; undefined -> stall=1 one cycle, taken the cycle after.
REQ-037 FLUSH_CYCLES=3, B taken, B in ID during flush -> flush=1 exactly 3 cycles, second B ignored, single take_branch pulse.
REQ-038 reset asserted in second FLUSH cycle -> next cycle flush=0, state RUN, flags_q=0000.

Source files
------------

// File: rtl/branch_resolve_pkg.sv
// Shared types for the branch resolve unit.
// FLAG_FWD_EN (macro) enables flag forwarding for B.LT.
package branch_resolve_pkg;

  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_B    = 2'b01,
    BR_CBZ  = 2'b10,
    BR_BLT  = 2'b11
  } br_type_t;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_STALL = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/branch_resolve_if.sv
// EX/ID inputs and redirect outputs of the branch resolve unit.
// master drives the candidate and flags; slave resolves.
interface branch_resolve_if #(
  parameter int ADDR_W = 64
);
  logic              ex_valid;
  logic              ex_set_flags;
  logic              alu_neg;
  logic              alu_zero;
  logic              alu_cout;
  logic              alu_ovf;
  logic              id_valid;
  logic [1:0]        id_br_type;
  logic              id_reg_zero;
  logic [ADDR_W-1:0] id_target;
  logic              take_branch;
  logic [ADDR_W-1:0] pc_target;
  logic              flush;
  logic              stall;
  logic [3:0]        flags_q;

  modport master (
    output ex_valid, ex_set_flags,
    output alu_neg, alu_zero, alu_cout, alu_ovf,
    output id_valid, id_br_type, id_reg_zero, id_target,
    input  take_branch, pc_target, flush, stall, flags_q
  );

  modport slave (
    input  ex_valid, ex_set_flags,
    input  alu_neg, alu_zero, alu_cout, alu_ovf,
    input  id_valid, id_br_type, id_reg_zero, id_target,
    output take_branch, pc_target, flush, stall, flags_q
  );
endinterface

// File: rtl/branch_resolve_flag_reg.sv
// Architectural NZCV register: load on enable,
// synchronous active-high clear.
module flag_reg (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [3:0] d,
  output logic [3:0] q
);

  // hold flags unless the EX instruction writes them
  always_ff @(posedge clk) begin
    if (reset)   q <= 4'b0000;
    else if (en) q <= d;
  end

endmodule

// File: rtl/branch_resolve.sv
// Resolves ID-stage branches and drives redirect/flush/stall.
// FLAG_FWD_EN: B.LT reads forwarded ALU flags instead of stalling.
module branch_resolve
  import branch_resolve_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int ADDR_W       = 64
) (
  input logic             clk,
  input logic             reset,
  branch_resolve_if.slave bus
);

  localparam logic [1:0] FC = 2'(FLUSH_CYCLES);

  state_t            state, state_n;
  logic [1:0]        cnt, cnt_n;
  logic              take_q, take_n;
  logic [ADDR_W-1:0] pc_q, pc_n;
  logic [3:0]        flags;
  logic              flag_we;
  logic              n_eff, v_eff;
  logic              taken;
  logic              hazard;
  br_type_t          br;

  assign flag_we = bus.ex_valid & bus.ex_set_flags;
  assign br      = br_type_t'(bus.id_br_type);

  flag_reg u_flags (
    .clk   (clk),
    .reset (reset),
    .en    (flag_we),
    .d     ({bus.alu_neg, bus.alu_zero,
             bus.alu_cout, bus.alu_ovf}),
    .q     (flags)
  );

`ifdef FLAG_FWD_EN
  assign n_eff  = flag_we ? bus.alu_neg : flags[FLAG_N];
  assign v_eff  = flag_we ? bus.alu_ovf : flags[FLAG_V];
  assign hazard = 1'b0;
`else
  assign n_eff  = flags[FLAG_N];
  assign v_eff  = flags[FLAG_V];
  assign hazard = flag_we && (br == BR_BLT);
`endif

  // branch condition for the candidate in ID
  always_comb begin
    taken = 1'b0;
    unique case (br)
      BR_B:    taken = 1'b1;
      BR_CBZ:  taken = bus.id_reg_zero;
      BR_BLT:  taken = n_eff ^ v_eff;
      default: taken = 1'b0;
    endcase
  end

  // next state, flush countdown and redirect target
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    take_n  = 1'b0;
    pc_n    = pc_q;
    unique case (state)
      S_RUN: begin
        if (bus.id_valid && hazard) begin
          state_n = S_STALL;
        end else if (bus.id_valid && taken) begin
          take_n  = 1'b1;
          pc_n    = bus.id_target;
          state_n = S_FLUSH;
          cnt_n   = FC;
        end
      end
      S_STALL: begin
        state_n = S_RUN;
        if (bus.id_valid && taken) begin
          take_n  = 1'b1;
          pc_n    = bus.id_target;
          state_n = S_FLUSH;
          cnt_n   = FC;
        end
      end
      S_FLUSH: begin
        if (cnt <= 2'd1) begin
          state_n = S_RUN;
          cnt_n   = 2'd0;
        end else begin
          cnt_n = cnt - 2'd1;
        end
      end
      default: begin
        state_n = S_RUN;
        cnt_n   = 2'd0;
      end
    endcase
  end

  // state and registered redirect outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_RUN;
      cnt    <= 2'd0;
      take_q <= 1'b0;
      pc_q   <= '0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      take_q <= take_n;
      pc_q   <= pc_n;
    end
  end

  assign bus.take_branch = take_q;
  assign bus.pc_target   = pc_q;
  assign bus.flush       = (state == S_FLUSH);
  assign bus.stall       = (state == S_STALL);
  assign bus.flags_q     = flags;

endmodule

// File: tb/tb_branch_resolve.sv
// Directed scoreboard bench for branch_resolve.
// Instance a: FLUSH_CYCLES=1; instance b: FLUSH_CYCLES=3.
module tb_branch_resolve;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  typedef struct {
    string       tag;
    bit          sel;
    logic        tb;
    logic [63:0] pc;
    logic        fl;
    logic        st;
    logic [3:0]  fq;
  } exp_t;

  exp_t exp_q[$];

  branch_resolve_if #(.ADDR_W(64)) a ();
  branch_resolve_if #(.ADDR_W(64)) b ();

  branch_resolve #(.FLUSH_CYCLES(1), .ADDR_W(64)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (a.slave)
  );

  branch_resolve #(.FLUSH_CYCLES(3), .ADDR_W(64)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input string fld,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s.%s observed=%0h expected=%0h",
             tag, fld, obs, exp);
    end
  endtask

  task automatic clr_a();
    a.ex_valid = 0; a.ex_set_flags = 0;
    a.alu_neg = 0; a.alu_zero = 0;
    a.alu_cout = 0; a.alu_ovf = 0;
    a.id_valid = 0; a.id_br_type = 2'b00;
    a.id_reg_zero = 0; a.id_target = '0;
  endtask

  task automatic clr_b();
    b.ex_valid = 0; b.ex_set_flags = 0;
    b.alu_neg = 0; b.alu_zero = 0;
    b.alu_cout = 0; b.alu_ovf = 0;
    b.id_valid = 0; b.id_br_type = 2'b00;
    b.id_reg_zero = 0; b.id_target = '0;
  endtask

  // push expectation for the coming edge, then pop and compare
  task automatic tick(input string tag, input bit sel,
                      input logic tb_e,
                      input logic [63:0] pc_e,
                      input logic fl_e, input logic st_e,
                      input logic [3:0] fq_e);
    exp_t e;
    exp_t g;
    e.tag = tag; e.sel = sel; e.tb = tb_e; e.pc = pc_e;
    e.fl = fl_e; e.st = st_e; e.fq = fq_e;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    g = exp_q.pop_front();
    if (g.sel) begin
      chk(g.tag, "take", 64'(b.take_branch), 64'(g.tb));
      chk(g.tag, "pc", b.pc_target, g.pc);
      chk(g.tag, "flush", 64'(b.flush), 64'(g.fl));
      chk(g.tag, "stall", 64'(b.stall), 64'(g.st));
      chk(g.tag, "flags", 64'(b.flags_q), 64'(g.fq));
    end else begin
      chk(g.tag, "take", 64'(a.take_branch), 64'(g.tb));
      chk(g.tag, "pc", a.pc_target, g.pc);
      chk(g.tag, "flush", 64'(a.flush), 64'(g.fl));
      chk(g.tag, "stall", 64'(a.stall), 64'(g.st));
      chk(g.tag, "flags", 64'(a.flags_q), 64'(g.fq));
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    clr_a();
    clr_b();
    reset = 1;
    tick("rst_a", 0, 0, 64'h0, 0, 0, 4'b0000);
    tick("rst_b", 1, 0, 64'h0, 0, 0, 4'b0000);
    reset = 0;
    for (int i = 0; i < 5; i++)
      tick("idle", 0, 0, 64'h0, 0, 0, 4'b0000);

    // SUBS result zero, then CBZ taken
    a.ex_valid = 1; a.ex_set_flags = 1; a.alu_zero = 1;
    tick("subs_z", 0, 0, 64'h0, 0, 0, 4'b0100);
    clr_a();
    a.id_valid = 1; a.id_br_type = 2'b10;
    a.id_reg_zero = 1; a.id_target = 64'h40;
    tick("cbz_t", 0, 1, 64'h40, 1, 0, 4'b0100);
    clr_a();
    tick("cbz_end", 0, 0, 64'h40, 0, 0, 4'b0100);
    a.id_valid = 1; a.id_br_type = 2'b10;
    a.id_reg_zero = 0; a.id_target = 64'h80;
    tick("cbz_nt", 0, 0, 64'h40, 0, 0, 4'b0100);
    clr_a();
    a.ex_valid = 1; a.ex_set_flags = 0; a.alu_neg = 1;
    tick("no_we", 0, 0, 64'h40, 0, 0, 4'b0100);

    // B.LT with N=1,V=0 taken
    a.ex_set_flags = 1;
    tick("flg_n", 0, 0, 64'h40, 0, 0, 4'b1000);
    clr_a();
    a.id_valid = 1; a.id_br_type = 2'b11;
    a.id_target = 64'h100;
    tick("blt_t", 0, 1, 64'h100, 1, 0, 4'b1000);
    clr_a();
    tick("blt_end", 0, 0, 64'h100, 0, 0, 4'b1000);

    // B.LT with N=1,V=1 not taken
    a.ex_valid = 1; a.ex_set_flags = 1;
    a.alu_neg = 1; a.alu_ovf = 1;
    tick("flg_nv", 0, 0, 64'h100, 0, 0, 4'b1001);
    clr_a();
    a.id_valid = 1; a.id_br_type = 2'b11;
    a.id_target = 64'h200;
    tick("blt_nt", 0, 0, 64'h100, 0, 0, 4'b1001);
    clr_a();

    // B alongside a flag write: no interaction
    a.ex_valid = 1; a.ex_set_flags = 1; a.alu_zero = 1;
    a.id_valid = 1; a.id_br_type = 2'b01;
    a.id_target = 64'h300;
    tick("b_we", 0, 1, 64'h300, 1, 0, 4'b0100);
    clr_a();
    tick("b_end", 0, 0, 64'h300, 0, 0, 4'b0100);

    // SUBS (N=1,V=0) in the same cycle as B.LT
    a.ex_valid = 1; a.ex_set_flags = 1; a.alu_neg = 1;
    a.id_valid = 1; a.id_br_type = 2'b11;
    a.id_target = 64'h500;
`ifdef FLAG_FWD_EN
    tick("fwd_t", 0, 1, 64'h500, 1, 0, 4'b1000);
    clr_a();
    tick("fwd_end", 0, 0, 64'h500, 0, 0, 4'b1000);
`else
    tick("stl", 0, 0, 64'h300, 0, 1, 4'b1000);
    a.ex_valid = 0; a.ex_set_flags = 0; a.alu_neg = 0;
    tick("stl_t", 0, 1, 64'h500, 1, 0, 4'b1000);
    clr_a();
    tick("stl_end", 0, 0, 64'h500, 0, 0, 4'b1000);
`endif

    // SUBS clearing N in the same cycle as B.LT: not taken
    a.ex_valid = 1; a.ex_set_flags = 1;
    a.id_valid = 1; a.id_br_type = 2'b11;
    a.id_target = 64'h600;
`ifdef FLAG_FWD_EN
    tick("fwd_nt", 0, 0, 64'h500, 0, 0, 4'b0000);
    clr_a();
`else
    tick("stl2", 0, 0, 64'h500, 0, 1, 4'b0000);
    a.ex_valid = 0; a.ex_set_flags = 0;
    tick("stl2_nt", 0, 0, 64'h500, 0, 0, 4'b0000);
    clr_a();
`endif
    tick("idle2", 0, 0, 64'h500, 0, 0, 4'b0000);

    // FLUSH_CYCLES=3, second B squashed during flush
    b.id_valid = 1; b.id_br_type = 2'b01;
    b.id_target = 64'h1000;
    tick("f3_1", 1, 1, 64'h1000, 1, 0, 4'b0000);
    b.id_target = 64'h2000;
    tick("f3_2", 1, 0, 64'h1000, 1, 0, 4'b0000);
    tick("f3_3", 1, 0, 64'h1000, 1, 0, 4'b0000);
    clr_b();
    tick("f3_end", 1, 0, 64'h1000, 0, 0, 4'b0000);
    tick("f3_idle", 1, 0, 64'h1000, 0, 0, 4'b0000);

    // reset in the second flush cycle
    b.ex_valid = 1; b.ex_set_flags = 1; b.alu_neg = 1;
    b.id_valid = 1; b.id_br_type = 2'b01;
    b.id_target = 64'h3000;
    tick("r_t", 1, 1, 64'h3000, 1, 0, 4'b1000);
    reset = 1;
    b.id_target = 64'h4000;
    tick("r_rst", 1, 0, 64'h0, 0, 0, 4'b0000);
    reset = 0;
    clr_b();
    tick("r_idle", 1, 0, 64'h0, 0, 0, 4'b0000);
    tick("r_a", 0, 0, 64'h0, 0, 0, 4'b0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
